// File: rtl/crank_sim.sv
// Crank/encoder position simulator with a built-in period timer.
// It runs in step mode (one-shot timer, advance on step) or free-run mode (auto-reload, advance on expiry).
module crank_sim #(
    parameter int POS_COUNT = 1440,
    parameter int TDC_COUNT = 2,
    parameter int MISSING   = 0,
    parameter int PERIOD_W  = 16,
    parameter int REV_W     = 8,
    parameter int POS_W     = $clog2(POS_COUNT)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mode,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period,
    input  logic                step,
    output logic                busy,
    output logic                done,
    output logic [POS_W-1:0]    pos,
    output logic [REV_W-1:0]    rev,
    output logic                tdc,
    output logic                tic,
    output logic                adv
);

    localparam int SEG = POS_COUNT / TDC_COUNT;
    localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(POS_COUNT - 1);
    localparam logic [POS_W-1:0]    SEG_LAST  = POS_W'(SEG - 1);
    localparam logic [POS_W-1:0]    GAP_START = POS_W'(POS_COUNT - MISSING);
    localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [POS_W-1:0]    seg_q, seg_d;
    logic [REV_W-1:0]    rev_q, rev_d;
    logic                tdc_q, tdc_d;
    logic                tic_pre_q, tic_pre_d;
    logic                tic_q;
    logic                adv_q;
    logic                done_q, done_d;
    logic                adv_evt;
    logic [POS_W-1:0]    np;
    logic [POS_W-1:0]    seg_np;
    logic                in_gap;

    // Timer: load wins; step mode counts down once, free-run reloads on reaching 1 (or 0).
    always_comb begin
        cnt_d   = cnt_q;
        per_d   = per_q;
        done_d  = 1'b0;
        adv_evt = 1'b0;
        if (load) begin
            per_d   = period;
            cnt_d   = period;
            adv_evt = !mode && step;
        end else if (!mode) begin
            adv_evt = step;
            done_d  = (cnt_q == CNT_ONE);
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if ((per_q != '0) && (cnt_q <= CNT_ONE)) begin
            adv_evt = 1'b1;
            cnt_d   = per_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // seg tracks pos modulo the TDC spacing, so tdc needs no divider.
    always_comb begin
        np        = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        seg_np    = (seg_q == SEG_LAST) ? '0 : seg_q + 1'b1;
        in_gap    = (MISSING != 0) && (np >= GAP_START);
        pos_d     = pos_q;
        seg_d     = seg_q;
        rev_d     = rev_q;
        tdc_d     = tdc_q;
        tic_pre_d = tic_pre_q;
        if (adv_evt) begin
            pos_d = np;
            seg_d = seg_np;
            tdc_d = (seg_np == '0);
            if (np == '0) begin
                rev_d = rev_q + 1'b1;
            end
            if (!in_gap) begin
                tic_pre_d = ~tic_pre_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            per_q     <= '0;
            pos_q     <= '0;
            seg_q     <= '0;
            rev_q     <= '0;
            tdc_q     <= 1'b0;
            tic_pre_q <= 1'b0;
            tic_q     <= 1'b0;
            adv_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            pos_q     <= pos_d;
            seg_q     <= seg_d;
            rev_q     <= rev_d;
            tdc_q     <= tdc_d;
            tic_pre_q <= tic_pre_d;
            tic_q     <= tic_pre_q;
            adv_q     <= adv_evt;
            done_q    <= done_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign done = done_q;
    assign pos  = pos_q;
    assign rev  = rev_q;
    assign tdc  = tdc_q;
    assign tic  = tic_q;
    assign adv  = adv_q;

endmodule

// File: doc/crank_sim.md
Name: crank_sim

Overview:
- Parametrised crank/encoder simulator with an integrated position-period timer. Successor to the fixed 1440-position, two-TDC step-only simulator and its 16-bit one-shot timer.
- Adds configurable resolution, TDC count and missing-tooth gap, a free-running mode with auto-reload period, and a revolution counter.
- Sits after the command FSM: the FSM issues load/step strobes; tic/tdc drive the pins and LED pulsegens.

Parameters:
- POS_COUNT, 1440: positions per revolution (≥4).
- TDC_COUNT, 2: TDC pulses per revolution. POS_COUNT must be an integer multiple of TDC_COUNT.
- MISSING, 0: positions at the end of each revolution (pos ≥ POS_COUNT-MISSING) where tic does not toggle. Must be < POS_COUNT/2.
- PERIOD_W, 16: timer/period width.
- REV_W, 8: revolution counter width.
- POS_W, $clog2(POS_COUNT): position width (derived).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = step mode (advance on step), 1 = free-run (advance on timer expiry).
- load  in  1  one-cycle strobe; latch period and start the timer.
- period  in  PERIOD_W  cycles per position / one-shot duration.
- step  in  1  one-cycle advance strobe (step mode only).
- busy  out  1  timer nonzero.
- done  out  1  one-cycle pulse when the one-shot timer expires (step mode).
- pos  out  POS_W  current position.
- rev  out  REV_W  completed revolutions, wraps.
- tdc  out  1  high while pos is a TDC position.
- tic  out  1  encoder square wave.
- adv  out  1  one-cycle pulse on every position advance.

Behaviour:
- Reset (async, resetn=0): cnt=0, per=0, pos=0, rev=0, tdc=0, tic=0, tic_=0, adv=0, done=0. All outputs are registered.
- Timer, load=1:
  - per<=period, cnt<=period.
  - load has priority over any decrement or reload in that cycle.
- Step mode (mode=0):
  - When cnt≠0 and no load, cnt decrements.
  - done=1 for exactly the cycle after cnt goes 1→0.
  - cnt never underflows; a load with period=0 produces no done.
  - adv_evt = step.
- Free-run mode (mode=1):
  - If per≠0 and cnt≤1 and no load: adv_evt=1, cnt<=per. The position therefore advances every per cycles.
  - If per=0: no advance and cnt holds 0.
  - step is ignored. done stays 0.
- Mode change takes effect on the next cycle. cnt is not reset by a mode change.
- On adv_evt, with next pos np = (pos==POS_COUNT-1) ? 0 : pos+1:
  - pos<=np; adv<=1.
  - rev<=rev+1 when np==0 (modulo 2^REV_W).
  - tdc<=(np mod (POS_COUNT/TDC_COUNT)==0).
  - tic_ toggles unless np ≥ POS_COUNT-MISSING; in the gap tic_ holds.
- Without adv_evt: pos, rev, tdc and tic_ hold; adv<=0.
- tic<=tic_ every cycle, so tic lags tdc/pos by one cycle.
- Latency: step at cycle N → pos/tdc/adv change at N+1 → tic changes at N+2.
- Step and load in the same cycle: both take effect.
- Reset mid-operation: all state clears immediately. The first adv after release moves pos 0→1.
- busy = (cnt≠0), combinational from the register.

Test Plan:
- Defaults, mode=0: pulse step 1440 times → pos wraps 1439→0 and rev=1. tdc is high after the steps landing on pos 720 and 0, low elsewhere. tic toggles on every step and lags pos by one cycle.
- mode=0, load with period=5 → busy high for 5 cycles. done pulses once, on the cycle after cnt reaches 0. Then load with period=0 → no done, busy stays 0.
- mode=1, load with period=3 → adv every 3 cycles. Over 30 cycles pos advances by 10. Then load with period=0 → pos freezes.
- POS_COUNT=24, TDC_COUNT=1, MISSING=2, free-run → tic holds across pos 22 and 23. tdc is high only when pos=0. rev increments once per 24 advances.
- Simultaneous step and load in mode=0 → pos+1 and cnt=period in the same cycle. step asserted in mode=1 → no extra advance.
- Assert resetn=0 asynchronously mid-count (pos=37, cnt=9) → all outputs zero before the next clk edge. After release, the first step gives pos=1.
